// File: rtl/mixsx_idx_gen.sv
// Index generator for mixsx32: slices random words into candidates, rejection-samples
// them against XWORDS32 and packs CWORDS64 accepted indices into d.
module mixsx_idx_gen #(
  parameter  int CWORDS64  = 2,
  parameter  int XWORDS32  = 4,
  localparam int IDX_WIDTH = $clog2(XWORDS32),
  localparam int FIELDS    = 32 / IDX_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CWORDS64*IDX_WIDTH-1:0] d,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic                          busy,
  output logic [15:0]                   rej_cnt
);

  localparam int KW = (CWORDS64 > 1) ? $clog2(CWORDS64) : 1;
  localparam int FW = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int WW = FIELDS * IDX_WIDTH;
  localparam logic [IDX_WIDTH:0] XLIM = (IDX_WIDTH + 1)'(XWORDS32);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_OUT} state_t;

  state_t                        r_state;
  logic [WW-1:0]                 r_word;
  logic [FW-1:0]                 r_f;
  logic [KW-1:0]                 r_k;
  logic [CWORDS64*IDX_WIDTH-1:0] r_d;
  logic [15:0]                   r_rej;

  logic [IDX_WIDTH-1:0] w_fields [FIELDS];
  logic [IDX_WIDTH-1:0] w_cand;
  logic                 w_accept;
  logic                 w_last_f;
  logic                 w_last_k;

  // Field 0 occupies the least significant bits of the captured word.
  generate
    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_field
      assign w_fields[gi] = r_word[gi*IDX_WIDTH +: IDX_WIDTH];
    end
  endgenerate

  assign w_cand   = w_fields[r_f];
  assign w_accept = {1'b0, w_cand} < XLIM;
  assign w_last_f = (r_f == FW'(FIELDS - 1));
  assign w_last_k = (r_k == KW'(CWORDS64 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_f     <= '0;
      r_k     <= '0;
      r_d     <= '0;
      r_rej   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= '0;
            r_d     <= '0;
            r_rej   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_word  <= in_word[WW-1:0];
            r_f     <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_accept) begin
            for (int k = 0; k < CWORDS64; k++) begin
              if (r_k == KW'(k)) r_d[k*IDX_WIDTH +: IDX_WIDTH] <= w_cand;
            end
            r_k <= r_k + 1'b1;
          end else if (r_rej != 16'hFFFF) begin
            r_rej <= r_rej + 16'd1;
          end
          // Completing the last slot wins over word exhaustion; leftover fields are dropped.
          if (w_accept && w_last_k) begin
            r_state <= S_OUT;
          end else if (w_last_f) begin
            r_state <= S_LOAD;
          end else begin
            r_f <= r_f + 1'b1;
          end
        end
        S_OUT: begin
          if (d_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == S_LOAD);
  assign d_valid  = (r_state == S_OUT);
  assign busy     = (r_state != S_IDLE);
  assign d        = r_d;
  assign rej_cnt  = r_rej;

endmodule

// File: tb/tb_mixsx_idx_gen.sv
// Bench for mixsx_idx_gen: instance 0 uses XWORDS32=4, instance 1 uses XWORDS32=3.
module tb_mixsx_idx_gen;

  typedef struct {
    logic [3:0]  d;
    logic [15:0] rej;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset_i    [2];
  logic        start_i    [2];
  logic [31:0] in_word_i  [2];
  logic        in_valid_i [2];
  logic        d_ready_i  [2];
  logic        in_ready_o [2];
  logic [3:0]  d_o        [2];
  logic        d_valid_o  [2];
  logic        busy_o     [2];
  logic [15:0] rej_o      [2];

  int   total = 0;
  int   bad   = 0;
  int   hs0   = 0;
  int   hs1   = 0;
  exp_t sb[$];

  mixsx_idx_gen #(.CWORDS64(2), .XWORDS32(4)) u_dut4 (
    .clk(clk), .reset(reset_i[0]), .start(start_i[0]), .in_word(in_word_i[0]),
    .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]), .d(d_o[0]),
    .d_valid(d_valid_o[0]), .d_ready(d_ready_i[0]), .busy(busy_o[0]), .rej_cnt(rej_o[0])
  );

  mixsx_idx_gen #(.CWORDS64(2), .XWORDS32(3)) u_dut3 (
    .clk(clk), .reset(reset_i[1]), .start(start_i[1]), .in_word(in_word_i[1]),
    .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]), .d(d_o[1]),
    .d_valid(d_valid_o[1]), .d_ready(d_ready_i[1]), .busy(busy_o[1]), .rej_cnt(rej_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid_i[0] && in_ready_o[0]) hs0 <= hs0 + 1;
    if (in_valid_i[1] && in_ready_o[1]) hs1 <= hs1 + 1;
  end

  // Starts a collection and feeds up to two words; lat counts cycles from the start edge
  // until d_valid is seen, loads counts cycles seen in LOAD.
  task automatic collect(input int s, input logic [31:0] w0, input logic [31:0] w1,
                         input int nwords, input int stall, input int pulse_at,
                         output int lat, output int loads, output logic to);
    int widx;
    widx  = 0;
    loads = 0;
    lat   = 0;
    to    = 1'b1;
    @(negedge clk);
    start_i[s] = 1'b1;
    @(posedge clk);
    #1 start_i[s] = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start_i[s] = (n == pulse_at);
      if (d_valid_o[s]) begin
        lat = n;
        to  = 1'b0;
        in_valid_i[s] = 1'b0;
        break;
      end
      if (in_ready_o[s]) begin
        loads++;
        if (loads > stall && widx < nwords) begin
          in_word_i[s]  = (widx == 0) ? w0 : w1;
          in_valid_i[s] = 1'b1;
          widx++;
        end else begin
          in_valid_i[s] = 1'b0;
        end
      end else begin
        in_valid_i[s] = 1'b0;
      end
    end
    start_i[s] = 1'b0;
  endtask

  task automatic finish_out(input int s);
    d_ready_i[s] = 1'b1;
    @(posedge clk);
    #1 d_ready_i[s] = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_i[0] = 1'b1;
    reset_i[1] = 1'b1;
    @(posedge clk);
    #1;
    reset_i[0] = 1'b0;
    reset_i[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      total++; if (busy_o[s] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_o[s]); end
      total++; if (in_ready_o[s] !== 1'b0) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 0", s, in_ready_o[s]); end
      total++; if (d_valid_o[s] !== 1'b0) begin bad++; $display("FAIL reset_d_valid[%0d]: got %b want 0", s, d_valid_o[s]); end
      total++; if (d_o[s] !== 4'h0) begin bad++; $display("FAIL reset_d[%0d]: got %h want 0", s, d_o[s]); end
      total++; if (rej_o[s] !== 16'h0) begin bad++; $display("FAIL reset_rej[%0d]: got %h want 0", s, rej_o[s]); end
    end
  endtask

  task automatic test_basic;
    int lat, loads; logic to; exp_t e;
    sb.push_back('{d: 4'hB, rej: 16'd0, lat: 4});
    d_ready_i[0] = 1'b1;
    collect(0, 32'h0000001B, 32'h0, 1, 0, 0, lat, loads, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got d_valid=0 want 1"); end
    total++; if (d_o[0] !== e.d) begin bad++; $display("FAIL basic_d: got %h want %h", d_o[0], e.d); end
    total++; if (rej_o[0] !== e.rej) begin bad++; $display("FAIL basic_rej: got %0d want %0d", rej_o[0], e.rej); end
    total++; if (lat != e.lat) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
    finish_out(0);
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL basic_idle: got busy=%b want 0", busy_o[0]); end
  endtask

  task automatic test_rejection(input string nm);
    int lat, loads; logic to; exp_t e;
    sb.push_back('{d: 4'h4, rej: 16'd1, lat: 5});
    d_ready_i[1] = 1'b1;
    collect(1, 32'h00000013, 32'h0, 1, 0, 0, lat, loads, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout: got d_valid=0 want 1", nm); end
    total++; if (d_o[1] !== e.d) begin bad++; $display("FAIL %s_d: got %h want %h", nm, d_o[1], e.d); end
    total++; if (rej_o[1] !== e.rej) begin bad++; $display("FAIL %s_rej: got %0d want %0d", nm, rej_o[1], e.rej); end
    total++; if (lat != e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e.lat); end
    finish_out(1);
  endtask

  task automatic test_word_wrap(input int pulse_at, input string nm);
    int lat, loads, h0; logic to; exp_t e;
    h0 = hs1;
    sb.push_back('{d: 4'h6, rej: 16'd15, lat: 20});
    d_ready_i[1] = 1'b0;
    collect(1, 32'hFFFFFFFE, 32'h00000001, 2, 0, pulse_at, lat, loads, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout: got d_valid=0 want 1", nm); end
    total++; if (hs1 - h0 != 2) begin bad++; $display("FAIL %s_handshakes: got %0d want 2", nm, hs1 - h0); end
    total++; if (d_o[1] !== e.d) begin bad++; $display("FAIL %s_d: got %h want %h", nm, d_o[1], e.d); end
    total++; if (rej_o[1] !== e.rej) begin bad++; $display("FAIL %s_rej: got %0d want %0d", nm, rej_o[1], e.rej); end
    total++; if (lat != e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e.lat); end
    finish_out(1);
    @(negedge clk);
    total++; if (busy_o[1] !== 1'b0) begin bad++; $display("FAIL %s_idle: got busy=%b want 0", nm, busy_o[1]); end
  endtask

  task automatic test_backpressure;
    int lat, loads; logic to; exp_t e;
    sb.push_back('{d: 4'hB, rej: 16'd0, lat: 4});
    d_ready_i[0] = 1'b0;
    collect(0, 32'h0000001B, 32'h0, 1, 0, 0, lat, loads, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout: got d_valid=0 want 1"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (d_valid_o[0] !== 1'b1) begin bad++; $display("FAIL bp_d_valid[%0d]: got %b want 1", c, d_valid_o[0]); end
      total++; if (d_o[0] !== e.d) begin bad++; $display("FAIL bp_d[%0d]: got %h want %h", c, d_o[0], e.d); end
      total++; if (in_ready_o[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready_o[0]); end
    end
    finish_out(0);
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL bp_busy: got %b want 0", busy_o[0]); end
    total++; if (d_valid_o[0] !== 1'b0) begin bad++; $display("FAIL bp_d_valid_drop: got %b want 0", d_valid_o[0]); end
    total++; if (d_o[0] !== e.d) begin bad++; $display("FAIL bp_d_held: got %h want %h", d_o[0], e.d); end
  endtask

  task automatic test_stall;
    int lat, loads; logic to; exp_t e;
    sb.push_back('{d: 4'hB, rej: 16'd0, lat: 7});
    d_ready_i[0] = 1'b1;
    collect(0, 32'h0000001B, 32'h0, 1, 3, 0, lat, loads, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: got d_valid=0 want 1"); end
    total++; if (loads != 4) begin bad++; $display("FAIL stall_load_cycles: got %0d want 4", loads); end
    total++; if (d_o[0] !== e.d) begin bad++; $display("FAIL stall_d: got %h want %h", d_o[0], e.d); end
    total++; if (lat != e.lat) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, e.lat); end
    finish_out(0);
  endtask

  task automatic test_reset_mid_scan;
    @(negedge clk);
    start_i[1] = 1'b1;
    @(posedge clk);
    #1 start_i[1] = 1'b0;
    @(negedge clk);
    in_word_i[1]  = 32'hFFFFFFFE;
    in_valid_i[1] = 1'b1;
    @(negedge clk);
    in_valid_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (d_o[1] !== 4'h2) begin bad++; $display("FAIL midscan_d: got %h want 2", d_o[1]); end
    total++; if (rej_o[1] !== 16'd2) begin bad++; $display("FAIL midscan_rej: got %0d want 2", rej_o[1]); end
    reset_i[1] = 1'b1;
    @(posedge clk);
    #1 reset_i[1] = 1'b0;
    total++; if (busy_o[1] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o[1]); end
    total++; if (d_o[1] !== 4'h0) begin bad++; $display("FAIL abort_d: got %h want 0", d_o[1]); end
    total++; if (rej_o[1] !== 16'd0) begin bad++; $display("FAIL abort_rej: got %0d want 0", rej_o[1]); end
    total++; if (in_ready_o[1] !== 1'b0) begin bad++; $display("FAIL abort_in_ready: got %b want 0", in_ready_o[1]); end
  endtask

  task automatic test_back_to_back;
    int lat, loads; logic to; exp_t e;
    sb.push_back('{d: 4'hB, rej: 16'd0, lat: 4});
    sb.push_back('{d: 4'h4, rej: 16'd0, lat: 4});
    d_ready_i[0] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      collect(0, (r == 0) ? 32'h0000001B : 32'h000000E4, 32'h0, 1, 0, 0, lat, loads, to);
      e = sb.pop_front();
      total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout[%0d]: got d_valid=0 want 1", r); end
      total++; if (d_o[0] !== e.d) begin bad++; $display("FAIL b2b_d[%0d]: got %h want %h", r, d_o[0], e.d); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", r, lat, e.lat); end
      finish_out(0);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset_i[s]    = 1'b0;
      start_i[s]    = 1'b0;
      in_word_i[s]  = 32'h0;
      in_valid_i[s] = 1'b0;
      d_ready_i[s]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_rejection("rejection");
    test_word_wrap(0, "wrap");
    test_backpressure();
    test_stall();
    test_word_wrap(5, "start_in_scan");
    test_reset_mid_scan();
    test_rejection("after_reset");
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mixsx_idx_gen.md
# mixsx_idx_gen

Upstream index generator for the `mixsx32` mixing stage. It consumes a stream of 32-bit random words over a valid/ready handshake and slices each word into `IDX_WIDTH`-bit candidate indices. Candidates are rejection-sampled against `XWORDS32`, and accepted ones are packed into the `CWORDS64`-entry index vector `d`. The packed vector is presented to the mixing stage with a hold-until-acknowledged handshake.

## Interface
Parameters:
- `CWORDS64`, default 2: number of indices to collect; matches the consumer's `CWORDS64`. Must be ≥1.
- `XWORDS32`, default 4: index range; accepted indices are in [0, `XWORDS32`-1]. Must be ≥2.
- `IDX_WIDTH`, derived as `$clog2(XWORDS32)`: bits per candidate index.
- `FIELDS`, derived as `32/IDX_WIDTH` (integer division): candidates per input word. Leftover high bits are ignored.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a new collection. Sampled only in IDLE.
- `in_word`, in, 32: random source word.
- `in_valid`, in, 1: `in_word` valid.
- `in_ready`, out, 1: block can accept `in_word`.
- `d`, out, `CWORDS64*IDX_WIDTH`: packed indices; slot k is at `d[k*IDX_WIDTH +: IDX_WIDTH]`.
- `d_valid`, out, 1: `d` complete and stable.
- `d_ready`, in, 1: consumer has taken `d`.
- `busy`, out, 1: high in any state other than IDLE.
- `rej_cnt`, out, 16: rejected candidates in the current collection. Saturates at 0xFFFF. Cleared on `start`.

## Operation
States are IDLE, LOAD, SCAN, OUT.
- IDLE:
  - `in_ready`=0, `d_valid`=0.
  - On `start`: clear the slot counter k, the `d` register and `rej_cnt`, then go to LOAD.
- LOAD:
  - `in_ready`=1 (driven combinationally from state).
  - On `in_valid`: capture `in_word` into the word register, set field counter f=0, go to SCAN.
- SCAN: evaluate one candidate per cycle, `cand = word[f*IDX_WIDTH +: IDX_WIDTH]`.
  - If `cand < XWORDS32`: write it to slot k and increment k. If k was `CWORDS64`-1, go to OUT. Any remaining fields in the word are discarded.
  - Otherwise: increment `rej_cnt` (saturating).
  - If the collection is not yet complete and f=`FIELDS`-1, go to LOAD. Otherwise increment f.
- OUT:
  - `d_valid`=1 and `d` is held constant.
  - On `d_ready`: go to IDLE. `d` keeps its value until the next `start`.
- Field order is LSB first. Slot order is ascending.
- When `XWORDS32` is a power of two, no candidate is ever rejected.
- `start` is ignored in LOAD, SCAN and OUT.
- `in_valid` is ignored outside LOAD.

Reset values: state IDLE, `d`=0, `d_valid`=0, `in_ready`=0, `busy`=0, `rej_cnt`=0, k=0, f=0.

## Timing
- `start` is sampled at edge t. LOAD is entered at t+1.
- With `in_valid` already high, the word is captured at edge t+1 and SCAN runs from t+2.
- With no rejections, `d_valid` rises `CWORDS64`+2 cycles after the `start` edge.
- Each rejection adds 1 cycle.
- Each word exhausted without completing the collection adds 1 LOAD cycle, plus any cycles of `in_valid` low.
- `d_ready` already high on the first OUT cycle gives a 1-cycle `d_valid` pulse; IDLE follows on the next cycle.
- Back-to-back collections: `start` asserted in the first IDLE cycle after OUT is accepted.
- `reset` takes priority in every state and aborts a collection mid-SCAN or mid-OUT. Outputs return to their reset values on the next cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `d_ready` or `in_valid` to any output.

## Test plan
- Basic collection (`CWORDS64`=2, `XWORDS32`=4): `start`, then `in_word`=0x0000001B with `in_valid` high.
  - Required: `d`=4'hB (slot0=3, slot1=2), `rej_cnt`=0.
  - Required: `d_valid` rises 4 cycles after the `start` edge.
- Rejection (`XWORDS32`=3): `in_word`=0x00000013.
  - Field 3 is rejected; 0 and 1 are accepted.
  - Required: `d`=4'h4, `rej_cnt`=1, `d_valid` 5 cycles after `start`.
- Word wrap (`XWORDS32`=3): first word 0xFFFFFFFE, then 0x00000001.
  - Required: exactly two `in_ready`/`in_valid` handshakes.
  - Required: `d`=4'h6, `rej_cnt`=15.
- Backpressure:
  - Hold `d_ready`=0 for 5 cycles in OUT. Required: `d` and `d_valid` stable, `in_ready`=0.
  - Then assert `d_ready`. Required: IDLE next cycle, `busy`=0.
- Stalled source: `in_valid` low for 3 cycles in LOAD.
  - Required: state stays LOAD and `in_ready` stays 1.
  - Required: result is identical to the basic case, 3 cycles later.
- Control robustness:
  - Pulse `start` during SCAN. Required: ignored; result unchanged.
  - Assert `reset` mid-SCAN. Required: next cycle state IDLE, `d`=0, `rej_cnt`=0.
  - Issue a new `start` after the reset. Required: it completes normally.
